// File: rtl/pulse_channel_scheduler.sv
// pulse_channel_scheduler
//   Multi-channel periodic-pulse controller. A shared prescaler divides clk
//   down to a base tick. Each output channel is independently configured at
//   run time to OFF, SOLID, free-running BLINK or a counted BURST.
//
// Ports
//   clk        system clock, all state on posedge
//   rst        synchronous reset, active-low
//   cfg_valid  config write request
//   cfg_ready  config write can be accepted this cycle (low in tick cycles)
//   cfg_chan   target channel; values >= NCH handshake but are ignored
//   cfg_mode   00 OFF, 01 SOLID, 10 BLINK, 11 BURST
//   cfg_period half-period in ticks (0 treated as 1)
//   cfg_count  BURST: number of high pulses
//   tick       one-clk pulse per base tick
//   out        channel outputs
//   busy       channel is blinking or running a burst
//   done       one-clk pulse when a burst completes
module pulse_channel_scheduler #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned NCH      = 4,
  parameter int unsigned PW       = 16,
  parameter int unsigned CW       = 8,
  localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned PSW     = $clog2(PRESCALE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CHW-1:0]  cfg_chan,
  input  logic [1:0]      cfg_mode,
  input  logic [PW-1:0]   cfg_period,
  input  logic [CW-1:0]   cfg_count,
  output logic            tick,
  output logic [NCH-1:0]  out,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  done
);

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeSolid = 2'b01,
    ModeBlink = 2'b10,
    ModeBurst = 2'b11
  } mode_e;

  // Shared prescaler
  logic [PSW-1:0] r_presc;
  logic           r_run;      // low only in the cycle right after reset
  logic           w_tick;
  logic           w_accept;
  logic [PW-1:0]  w_per_eff;

  assign w_tick    = (r_presc == PSW'(PRESCALE - 1));
  assign tick      = w_tick;
  // Writes are held off during tick cycles so a channel never sees both.
  assign cfg_ready = r_run & ~w_tick;
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_per_eff = (cfg_period == '0) ? PW'(1) : cfg_period;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Per-channel state
  mode_e          r_mode [NCH];
  logic [PW-1:0]  r_per  [NCH];  // effective half-period, always >= 1 once loaded
  logic [PW-1:0]  r_cnt  [NCH];
  logic [CW:0]    r_rem  [NCH];  // toggles left in a burst (2 per pulse)
  logic [NCH-1:0] r_out;
  logic [NCH-1:0] r_busy;
  logic [NCH-1:0] r_done;

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        r_mode[i] <= ModeOff;
        r_per[i]  <= '0;
        r_cnt[i]  <= '0;
        r_rem[i]  <= '0;
      end
      r_out  <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        r_done[i] <= 1'b0;
        if (w_accept && (cfg_chan == CHW'(i))) begin
          // A rewrite replaces all state; an aborted burst gets no done.
          r_mode[i] <= mode_e'(cfg_mode);
          r_per[i]  <= w_per_eff;
          r_cnt[i]  <= '0;
          r_rem[i]  <= '0;
          unique case (mode_e'(cfg_mode))
            ModeOff: begin
              r_out[i]  <= 1'b0;
              r_busy[i] <= 1'b0;
            end
            ModeSolid: begin
              r_out[i]  <= 1'b1;
              r_busy[i] <= 1'b0;
            end
            ModeBlink: begin
              r_out[i]  <= 1'b0;
              r_busy[i] <= 1'b1;
            end
            ModeBurst: begin
              r_out[i] <= 1'b0;
              r_rem[i] <= {cfg_count, 1'b0};
              if (cfg_count == '0) begin
                // Empty burst completes immediately.
                r_busy[i] <= 1'b0;
                r_done[i] <= 1'b1;
                r_mode[i] <= ModeOff;
              end else begin
                r_busy[i] <= 1'b1;
              end
            end
          endcase
        end else if (w_tick && r_busy[i]) begin
          if (r_cnt[i] == r_per[i] - 1'b1) begin
            r_cnt[i] <= '0;
            r_out[i] <= ~r_out[i];
            if (r_mode[i] == ModeBurst) begin
              r_rem[i] <= r_rem[i] - 1'b1;
              // Last toggle is always a falling edge since r_rem starts even.
              if (r_rem[i] == (CW + 1)'(1)) begin
                r_busy[i] <= 1'b0;
                r_done[i] <= 1'b1;
                r_mode[i] <= ModeOff;
              end
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_channel_scheduler.sv
// Testbench for pulse_channel_scheduler. Two instances: dut0 with
// PRESCALE=4/NCH=4/PW=16/CW=8 for the main behaviour, dut1 with
// PRESCALE=2/NCH=3/PW=8/CW=4 so the all-ones period and an out-of-range
// channel can be exercised in a short run. A tick-counting reference model
// predicts every cycle's outputs into a queue; a monitor pops and compares.
module tb_pulse_channel_scheduler;

  localparam int P0 = 4;
  localparam int N0 = 4;
  localparam int P1 = 2;
  localparam int N1 = 3;

  localparam int MOff   = 0;
  localparam int MSolid = 1;
  localparam int MBlink = 2;
  localparam int MBurst = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       v0, rdy0, tk0;
  logic [1:0] ch0, md0;
  logic [15:0] pr0;
  logic [7:0] ct0;
  logic [3:0] out0, bsy0, dn0;

  logic       v1, rdy1, tk1;
  logic [1:0] ch1, md1;
  logic [7:0] pr1;
  logic [3:0] ct1;
  logic [2:0] out1, bsy1, dn1;

  pulse_channel_scheduler #(
    .PRESCALE(P0), .NCH(N0), .PW(16), .CW(8)
  ) dut0 (
    .clk(clk), .rst(rst), .cfg_valid(v0), .cfg_ready(rdy0), .cfg_chan(ch0),
    .cfg_mode(md0), .cfg_period(pr0), .cfg_count(ct0), .tick(tk0), .out(out0),
    .busy(bsy0), .done(dn0)
  );

  pulse_channel_scheduler #(
    .PRESCALE(P1), .NCH(N1), .PW(8), .CW(4)
  ) dut1 (
    .clk(clk), .rst(rst), .cfg_valid(v1), .cfg_ready(rdy1), .cfg_chan(ch1),
    .cfg_mode(md1), .cfg_period(pr1), .cfg_count(ct1), .tick(tk1), .out(out1),
    .busy(bsy1), .done(dn1)
  );

  typedef struct packed {
    logic       tick;
    logic       ready;
    logic [3:0] out;
    logic [3:0] busy;
    logic [3:0] done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: each channel remembers its mode, effective period, and
  // how many ticks it has seen since its write; out is the parity of elapsed
  // whole half-periods.
  int m_presc [2];
  bit m_run   [2];
  int m_mode  [2][4];
  int m_pe    [2][4];
  int m_n     [2][4];
  int m_tgt   [2][4];
  bit m_done  [2][4];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int pre, nch, chn, mode, per, cnt;
      bit vld, tk, rd;
      exp_t e;
      pre  = (d == 0) ? P0 : P1;
      nch  = (d == 0) ? N0 : N1;
      vld  = (d == 0) ? v0 : v1;
      chn  = (d == 0) ? int'(ch0) : int'(ch1);
      mode = (d == 0) ? int'(md0) : int'(md1);
      per  = (d == 0) ? int'(pr0) : int'(pr1);
      cnt  = (d == 0) ? int'(ct0) : int'(ct1);
      if (!rst) begin
        m_presc[d] = 0;
        m_run[d]   = 1'b0;
        for (int c = 0; c < 4; c++) begin
          m_mode[d][c] = MOff;
          m_n[d][c]    = 0;
          m_done[d][c] = 1'b0;
          m_pe[d][c]   = 1;
          m_tgt[d][c]  = 0;
        end
      end else begin
        tk = (m_presc[d] == pre - 1);
        rd = m_run[d] && !tk;
        for (int c = 0; c < 4; c++) m_done[d][c] = 1'b0;
        if (tk) begin
          for (int c = 0; c < nch; c++) begin
            if (m_mode[d][c] == MBlink) m_n[d][c]++;
            if (m_mode[d][c] == MBurst) begin
              m_n[d][c]++;
              if (m_n[d][c] / m_pe[d][c] >= m_tgt[d][c]) begin
                m_mode[d][c] = MOff;
                m_done[d][c] = 1'b1;
              end
            end
          end
        end
        if (vld && rd && chn < nch) begin
          m_mode[d][chn] = mode;
          m_pe[d][chn]   = (per == 0) ? 1 : per;
          m_n[d][chn]    = 0;
          m_tgt[d][chn]  = 2 * cnt;
          if (mode == MBurst && cnt == 0) begin
            m_mode[d][chn] = MOff;
            m_done[d][chn] = 1'b1;
          end
        end
        m_presc[d] = (m_presc[d] + 1) % pre;
        m_run[d]   = 1'b1;
      end
      e.tick  = (m_presc[d] == pre - 1);
      e.ready = m_run[d] && !e.tick;
      e.out   = '0;
      e.busy  = '0;
      e.done  = '0;
      for (int c = 0; c < nch; c++) begin
        case (m_mode[d][c])
          MSolid: e.out[c] = 1'b1;
          MBlink, MBurst: begin
            e.out[c]  = ((m_n[d][c] / m_pe[d][c]) % 2) == 1;
            e.busy[c] = 1'b1;
          end
          default: e.out[c] = 1'b0;
        endcase
        e.done[c] = m_done[d][c];
      end
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  end

  task automatic cmp(input string nm, input int d, input logic [3:0] act,
                     input logic [3:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL dut%0d %s cycle %0d: got %h, expected %h", d, nm, cyc, act, want);
    end
  endtask

  // Monitor: compare on the falling edge, away from the update edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("tick",  0, {3'b0, tk0},  {3'b0, e.tick});
      cmp("ready", 0, {3'b0, rdy0}, {3'b0, e.ready});
      cmp("out",   0, out0, e.out);
      cmp("busy",  0, bsy0, e.busy);
      cmp("done",  0, dn0,  e.done);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("tick",  1, {3'b0, tk1},  {3'b0, e.tick});
      cmp("ready", 1, {3'b0, rdy1}, {3'b0, e.ready});
      cmp("out",   1, {1'b0, out1}, e.out);
      cmp("busy",  1, {1'b0, bsy1}, e.busy);
      cmp("done",  1, {1'b0, dn1},  e.done);
    end
  end

  // Issue one write; called just after a falling edge. Holds valid until
  // the DUT shows ready, bounded.
  task automatic wr(input int d, input int chn, input int mode, input int per,
                    input int cnt);
    bit ok;
    ok = 1'b0;
    if (d == 0) begin
      v0 = 1'b1; ch0 = 2'(chn); md0 = 2'(mode); pr0 = 16'(per); ct0 = 8'(cnt);
    end else begin
      v1 = 1'b1; ch1 = 2'(chn); md1 = 2'(mode); pr1 = 8'(per); ct1 = 4'(cnt);
    end
    for (int k = 0; k < 20 && !ok; k++) begin
      if (((d == 0) ? rdy0 : rdy1) == 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL dut%0d handshake cycle %0d: got no cfg_ready, expected ready within 20",
               d, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    v0 = 1'b0; ch0 = '0; md0 = '0; pr0 = '0; ct0 = '0;
    v1 = 1'b0; ch1 = '0; md1 = '0; pr1 = '0; ct1 = '0;
    idle(3);
    rst = 1'b1;
    idle(14);

    // Blink ch1 period 2, then a 3-pulse burst on ch2 with period 1
    wr(0, 1, MBlink, 2, 0);
    idle(40);
    wr(0, 2, MBurst, 1, 3);
    idle(40);

    // Write held across a tick cycle, empty burst
    for (int k = 0; k < 10 && !tk0; k++) @(negedge clk);
    wr(0, 3, MBurst, 5, 0);
    idle(6);

    // Rewrite mid-burst, then reset mid-blink
    wr(0, 2, MBurst, 2, 5);
    idle(10);
    wr(0, 2, MSolid, 0, 0);
    idle(20);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(10);

    // Period 0 acts as 1; out-of-range channel; all-ones period on dut1
    wr(0, 0, MBlink, 0, 0);
    idle(20);
    wr(1, 3, MSolid, 1, 0);
    idle(4);
    wr(1, 0, MBlink, 255, 0);
    wr(1, 1, MBurst, 255, 1);
    idle(1200);

    // Randomized writes across both instances
    for (int t = 0; t < 300; t++) begin
      int d;
      d = int'($urandom_range(0, 1));
      wr(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
         int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 10)));
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
